mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 159 +++++++++++++++
 tb/tb_mc_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset control FSM with sticky illegal flag.
// Optional retired-instruction counter enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic        EXTOp,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic [1:0]  NPCOp,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;

  logic w_rtype, w_addu, w_subu, w_jr, w_nop;
  logic w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_legal;
  logic w_pcwr, w_irwr, w_regwr, w_memwr;
  logic [1:0] w_regdst, w_wdsel, w_npcop;

  assign w_rtype = (opcode == 6'b000000);
  assign w_addu  = w_rtype && (funct == 6'b100001);
  assign w_subu  = w_rtype && (funct == 6'b100011);
  assign w_jr    = w_rtype && (funct == 6'b001000);
  assign w_nop   = w_rtype && (funct == 6'b000000);
  assign w_ori   = (opcode == 6'b001101);
  assign w_lui   = (opcode == 6'b001111);
  assign w_lw    = (opcode == 6'b100011);
  assign w_sw    = (opcode == 6'b101011);
  assign w_beq   = (opcode == 6'b000100);
  assign w_j     = (opcode == 6'b000010);
  assign w_jal   = (opcode == 6'b000011);
  assign w_legal = w_addu | w_subu | w_jr | w_nop | w_ori | w_lui |
                   w_lw | w_sw | w_beq | w_j | w_jal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_pcwr   = 1'b0;
    w_irwr   = 1'b0;
    w_regwr  = 1'b0;
    w_memwr  = 1'b0;
    w_regdst = 2'b00;
    w_wdsel  = 2'b00;
    w_npcop  = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irwr = 1'b1;
        w_pcwr = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        w_next = S_FETCH;
        if (w_addu | w_subu | w_ori | w_lui) begin
          w_next = S_WB;
        end else if (w_lw | w_sw) begin
          w_next = S_MEM;
        end else if (w_beq) begin
          w_pcwr  = zero;
          w_npcop = 2'b01;
        end else if (w_j) begin
          w_pcwr  = 1'b1;
          w_npcop = 2'b10;
        end else if (w_jal) begin
          w_pcwr   = 1'b1;
          w_npcop  = 2'b10;
          w_regwr  = 1'b1;
          w_regdst = 2'b10;
          w_wdsel  = 2'b10;
        end else if (w_jr) begin
          w_pcwr  = 1'b1;
          w_npcop = 2'b11;
        end
      end
      S_MEM: begin
        w_memwr = w_sw;
        if (mem_ready) w_next = w_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        w_regwr  = 1'b1;
        w_regdst = (w_addu | w_subu) ? 2'b01 : 2'b00;
        w_wdsel  = w_lw ? 2'b01 : 2'b00;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  // Write enables are gated by reset directly so an abort takes effect without a clock.
  assign PCWr    = w_pcwr  & ~reset;
  assign IRWr    = w_irwr  & ~reset;
  assign RegWr   = w_regwr & ~reset;
  assign MemWr   = w_memwr & ~reset;
  assign RegDst  = w_regdst;
  assign WDSel   = w_wdsel;
  assign NPCOp   = w_npcop;
  assign state   = r_state;
  assign illegal = r_illegal;

  assign EXTOp  = w_ori | w_lui;
  assign ALUSrc = w_ori | w_lui | w_lw | w_sw;
  always_comb begin
    ALUOp = 2'b00;
    if (w_subu | w_beq) ALUOp = 2'b01;
    else if (w_ori)     ALUOp = 2'b10;
    else if (w_lui)     ALUOp = 2'b11;
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_instr_cnt;
  logic        w_retire;

  assign w_retire = (w_next == S_FETCH) &&
                    (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_instr_cnt <= 32'd0;
    else if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
  end

  assign instr_cnt = r_instr_cnt;
`else
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl.
// Observed vector: {state, PCWr, IRWr, RegWr, MemWr, NPCOp, RegDst, WDSel}.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  state;
  logic        PCWr, IRWr, RegWr, MemWr, EXTOp, ALUSrc, illegal;
  logic [1:0]  ALUOp, RegDst, WDSel, NPCOp;
  logic [31:0] instr_cnt;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [12:0] obs;

`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [12:0] E_RST    = 13'b000_0000_00_00_00;
  localparam logic [12:0] E_FETCH  = 13'b000_1100_00_00_00;
  localparam logic [12:0] E_DEC    = 13'b001_0000_00_00_00;
  localparam logic [12:0] E_EXEC   = 13'b010_0000_00_00_00;
  localparam logic [12:0] E_WB_R   = 13'b100_0010_00_01_00;
  localparam logic [12:0] E_WB_I   = 13'b100_0010_00_00_00;
  localparam logic [12:0] E_WB_LW  = 13'b100_0010_00_00_01;
  localparam logic [12:0] E_MEM_LW = 13'b011_0000_00_00_00;
  localparam logic [12:0] E_MEM_SW = 13'b011_0001_00_00_00;
  localparam logic [12:0] E_BEQ0   = 13'b010_0000_01_00_00;
  localparam logic [12:0] E_BEQ1   = 13'b010_1000_01_00_00;
  localparam logic [12:0] E_J      = 13'b010_1000_10_00_00;
  localparam logic [12:0] E_JAL    = 13'b010_1010_10_10_10;
  localparam logic [12:0] E_JR     = 13'b010_1000_11_00_00;
  localparam logic [12:0] E_HALT   = 13'b111_0000_00_00_00;

  mc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .state     (state),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .RegWr     (RegWr),
    .MemWr     (MemWr),
    .EXTOp     (EXTOp),
    .ALUOp     (ALUOp),
    .ALUSrc    (ALUSrc),
    .RegDst    (RegDst),
    .WDSel     (WDSel),
    .NPCOp     (NPCOp),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {state, PCWr, IRWr, RegWr, MemWr, NPCOp, RegDst, WDSel};

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests_run++;
    if (obs !== E_RST || illegal !== 1'b0 || instr_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: got obs=%b ill=%b cnt=%h want obs=%b ill=0 cnt=0", obs, illegal, instr_cnt, E_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (obs !== E_FETCH) begin
      tests_failed++;
      $display("FAIL reset_first_fetch: got %b want %b", obs, E_FETCH);
    end
  endtask

  task automatic test_addu();
    logic [12:0] ex [5];
    ex = '{E_FETCH, E_DEC, E_EXEC, E_WB_R, E_FETCH};
    opcode = 6'b000000; funct = 6'b100001; zero = 1'bx;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (obs !== ex[i]) begin
        tests_failed++;
        $display("FAIL addu cyc%0d: got %b want %b", i, obs, ex[i]);
      end
      if (i < 4) @(negedge clk);
    end
    zero = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    tests_run++;
    if (instr_cnt !== (PERF ? exp_cnt : 32'd0)) begin
      tests_failed++;
      $display("FAIL addu_cnt: got %h want %h", instr_cnt, PERF ? exp_cnt : 32'd0);
    end
  endtask

  task automatic test_alu_i();
    logic [5:0]  ops [3];
    logic [5:0]  fns [3];
    logic [12:0] wbs [3];
    ops = '{6'b001101, 6'b001111, 6'b000000};
    fns = '{6'b000000, 6'b000000, 6'b100011};
    wbs = '{E_WB_I, E_WB_I, E_WB_R};
    for (int k = 0; k < 3; k++) begin
      logic [12:0] ex [5];
      ex = '{E_FETCH, E_DEC, E_EXEC, wbs[k], E_FETCH};
      opcode = ops[k]; funct = fns[k];
      for (int i = 0; i < 5; i++) begin
        #1;
        tests_run++;
        if (obs !== ex[i]) begin
          tests_failed++;
          $display("FAIL alu op=%b cyc%0d: got %b want %b", ops[k], i, obs, ex[i]);
        end
        if (i < 4) @(negedge clk);
      end
      exp_cnt = exp_cnt + 32'd1;
    end
  endtask

  task automatic test_lw_wait();
    logic [12:0] ex [8];
    ex = '{E_FETCH, E_DEC, E_EXEC, E_MEM_LW, E_MEM_LW, E_MEM_LW, E_WB_LW, E_FETCH};
    opcode = 6'b100011; funct = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      mem_ready = (i >= 5);
      #1;
      tests_run++;
      if (obs !== ex[i]) begin
        tests_failed++;
        $display("FAIL lw_wait cyc%0d: got %b want %b", i, obs, ex[i]);
      end
      if (i < 7) @(negedge clk);
    end
    mem_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    tests_run++;
    if (instr_cnt !== (PERF ? exp_cnt : 32'd0)) begin
      tests_failed++;
      $display("FAIL lw_cnt: got %h want %h", instr_cnt, PERF ? exp_cnt : 32'd0);
    end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      logic [12:0] ex [4];
      ex = '{E_FETCH, E_DEC, (k == 0) ? E_BEQ0 : E_BEQ1, E_FETCH};
      opcode = 6'b000100; funct = 6'b000000; zero = (k == 1);
      for (int i = 0; i < 4; i++) begin
        #1;
        tests_run++;
        if (obs !== ex[i]) begin
          tests_failed++;
          $display("FAIL beq zero=%0d cyc%0d: got %b want %b", k, i, obs, ex[i]);
        end
        if (i < 3) @(negedge clk);
      end
      exp_cnt = exp_cnt + 32'd1;
    end
    zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [5:0]  ops [4];
    logic [5:0]  fns [4];
    logic [12:0] exs [4];
    ops = '{6'b000011, 6'b000010, 6'b000000, 6'b000000};
    fns = '{6'b000000, 6'b000000, 6'b001000, 6'b000000};
    exs = '{E_JAL, E_J, E_JR, E_EXEC};
    for (int k = 0; k < 4; k++) begin
      logic [12:0] ex [4];
      ex = '{E_FETCH, E_DEC, exs[k], E_FETCH};
      opcode = ops[k]; funct = fns[k];
      for (int i = 0; i < 4; i++) begin
        #1;
        tests_run++;
        if (obs !== ex[i]) begin
          tests_failed++;
          $display("FAIL jump op=%b fn=%b cyc%0d: got %b want %b", ops[k], fns[k], i, obs, ex[i]);
        end
        if (i < 3) @(negedge clk);
      end
      exp_cnt = exp_cnt + 32'd1;
    end
    tests_run++;
    if (instr_cnt !== (PERF ? exp_cnt : 32'd0)) begin
      tests_failed++;
      $display("FAIL jumps_cnt: got %h want %h", instr_cnt, PERF ? exp_cnt : 32'd0);
    end
  endtask

  task automatic test_sw_reset_wrap();
    logic [12:0] ex [5];
    logic [12:0] ex2 [4];
    ex = '{E_FETCH, E_DEC, E_EXEC, E_MEM_SW, E_MEM_SW};
    opcode = 6'b101011; funct = 6'b000000; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (obs !== ex[i]) begin
        tests_failed++;
        $display("FAIL sw cyc%0d: got %b want %b", i, obs, ex[i]);
      end
      if (i < 4) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (obs !== E_RST || instr_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL sw_abort: got obs=%b cnt=%h want obs=%b cnt=0", obs, instr_cnt, E_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 32'd0;
`ifdef MC_CTRL_PERF_EN
    dut.r_instr_cnt = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
`endif
    ex2 = '{E_FETCH, E_DEC, E_EXEC, E_FETCH};
    opcode = 6'b000000; funct = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (obs !== ex2[i]) begin
        tests_failed++;
        $display("FAIL nop_after_abort cyc%0d: got %b want %b", i, obs, ex2[i]);
      end
      if (i < 3) @(negedge clk);
    end
    exp_cnt = exp_cnt + 32'd1;
    tests_run++;
    if (instr_cnt !== (PERF ? exp_cnt : 32'd0)) begin
      tests_failed++;
      $display("FAIL cnt_wrap: got %h want %h", instr_cnt, PERF ? exp_cnt : 32'd0);
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; funct = 6'b000000;
    for (int i = 0; i < 22; i++) begin
      logic [12:0] ex;
      logic        ex_ill;
      ex     = (i == 0) ? E_FETCH : (i == 1) ? E_DEC : E_HALT;
      ex_ill = (i >= 2);
      #1;
      tests_run++;
      if (obs !== ex || illegal !== ex_ill) begin
        tests_failed++;
        $display("FAIL illegal cyc%0d: got obs=%b ill=%b want obs=%b ill=%b", i, obs, illegal, ex, ex_ill);
      end
      if (i < 21) @(negedge clk);
    end
  endtask

  task automatic test_decode();
    logic [5:0] ops [7];
    logic [5:0] fns [7];
    logic [3:0] dec [7];
    ops = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100};
    fns = '{6'b100001, 6'b100011, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    dec = '{4'b0_00_0, 4'b0_01_0, 4'b1_10_1, 4'b1_11_1, 4'b0_00_1, 4'b0_00_1, 4'b0_01_0};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      opcode = ops[k]; funct = fns[k];
      #1;
      tests_run++;
      if ({EXTOp, ALUOp, ALUSrc} !== dec[k] || obs !== E_HALT) begin
        tests_failed++;
        $display("FAIL decode op=%b fn=%b: got dec=%b obs=%b want dec=%b obs=%b", ops[k], fns[k], {EXTOp, ALUOp, ALUSrc}, obs, dec[k], E_HALT);
      end
    end
  endtask

  task automatic test_reset_from_halt();
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (state !== 3'd0 || illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_reset: got state=%0d ill=%b want state=0 ill=0", state, illegal);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_bad_funct();
    opcode = 6'b000000; funct = 6'b100000;
    for (int i = 0; i < 3; i++) begin
      logic [12:0] ex;
      ex = (i == 0) ? E_FETCH : (i == 1) ? E_DEC : E_HALT;
      #1;
      tests_run++;
      if (obs !== ex || illegal !== (i == 2)) begin
        tests_failed++;
        $display("FAIL bad_funct cyc%0d: got obs=%b ill=%b want obs=%b ill=%b", i, obs, illegal, ex, (i == 2));
      end
      if (i < 2) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_alu_i();
    test_lw_wait();
    test_beq();
    test_jumps();
    test_sw_reset_wrap();
    test_illegal();
    test_decode();
    test_reset_from_halt();
    test_bad_funct();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
